mem_arbiter_rr: RTL and testbench

- Two-requester memory arbiter between the cpu's instruction port (imemory) and data port (dmemory) and the single SoC memory port that the address decoder consumes.
- Captures single-cycle requests into one-entry per-port holding registers and grants ownership round-robin.
- Issues one registered request downstream at a time and routes the response back to the owning port.
- Adds a response watchdog: an access that is never acknowledged completes with mem_error instead of hanging the core.

---
 rtl/mem_arbiter_rr.sv | 138 +++++++++++++
 tb/tb_mem_arbiter_rr.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter that merges the cpu instruction and data ports onto one memory port.
// Each port has a one-entry holding register. A watchdog turns a missing response into a bus error.

package mem_arbiter_rr_pkg;
  localparam int unsigned addr_width = 32;
  localparam int unsigned data_width = 32;
  localparam int unsigned strb_width = 4;

  typedef struct packed {
    logic                  mem_valid;
    logic                  mem_instr;
    logic [addr_width-1:0] mem_addr;
    logic [data_width-1:0] mem_wdata;
    logic [strb_width-1:0] mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic                  mem_ready;
    logic                  mem_error;
    logic [data_width-1:0] mem_rdata;
  } mem_out_type;

  localparam mem_in_type  init_mem_in  = '0;
  localparam mem_out_type init_mem_out = '0;
endpackage

module mem_arbiter_rr
  import mem_arbiter_rr_pkg::*;
#(
  parameter int unsigned timeout_cycles = 1023,
  parameter int unsigned cnt_width      = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  mem_in,
  input  mem_out_type mem_out
);

  typedef enum logic [1:0] {st_idle, st_busy_i, st_busy_d} state_t;
  typedef enum logic {port_instr, port_data} port_t;

  state_t               state;
  state_t               state_nxt;
  port_t                last_grant;
  mem_in_type           pend_i;
  mem_in_type           pend_d;
  logic [cnt_width-1:0] wd;
  logic                 grant_i;
  logic                 grant_d;
  logic                 expired;
  logic                 done;
  mem_out_type          resp;

  // Grant selection, response routing and watchdog expiry; a pending entry is marked by its stored mem_valid.
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    done      = 1'b0;
    resp      = init_mem_out;
    imem_out  = init_mem_out;
    dmem_out  = init_mem_out;
    expired   = (timeout_cycles != 0) && (wd == cnt_width'(timeout_cycles));

    case (state)
      st_idle: begin
        if (pend_i.mem_valid && pend_d.mem_valid) begin
          if (last_grant == port_instr) grant_d = 1'b1;
          else                          grant_i = 1'b1;
        end else if (pend_i.mem_valid) begin
          grant_i = 1'b1;
        end else if (pend_d.mem_valid) begin
          grant_d = 1'b1;
        end
        if (grant_i) state_nxt = st_busy_i;
        if (grant_d) state_nxt = st_busy_d;
      end
      st_busy_i, st_busy_d: begin
        // A real response takes precedence over a watchdog expiry in the same cycle.
        if (mem_out.mem_ready) begin
          resp = mem_out;
          done = 1'b1;
        end else if (expired) begin
          resp.mem_ready = 1'b1;
          resp.mem_error = 1'b1;
          done           = 1'b1;
        end
        if (done) state_nxt = st_idle;
        if (state == st_busy_i) imem_out = resp;
        else                    dmem_out = resp;
      end
      default: state_nxt = st_idle;
    endcase
  end

  // State, holding registers, issued request and watchdog.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= st_idle;
      last_grant <= port_instr;
      pend_i     <= init_mem_in;
      pend_d     <= init_mem_in;
      wd         <= '0;
      mem_in     <= init_mem_in;
    end else begin
      state <= state_nxt;

      if (grant_i)
        pend_i <= init_mem_in;
      else if (imem_in.mem_valid && !pend_i.mem_valid)
        pend_i <= imem_in;

      if (grant_d)
        pend_d <= init_mem_in;
      else if (dmem_in.mem_valid && !pend_d.mem_valid)
        pend_d <= dmem_in;

      if (grant_i) begin
        mem_in     <= pend_i;
        last_grant <= port_instr;
        wd         <= '0;
      end else if (grant_d) begin
        mem_in     <= pend_d;
        last_grant <= port_data;
        wd         <= '0;
      end else begin
        // Address/data stay on the bus after issue; only the valid strobe drops.
        mem_in.mem_valid <= 1'b0;
        if (state != st_idle) wd <= wd + cnt_width'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: fetch latency, round-robin ties, error passthrough,
// watchdog expiry, request overlap and asynchronous reset mid-transaction.

module tb_mem_arbiter_rr;
  import mem_arbiter_rr_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  mem_in_type  imem_in;
  mem_out_type imem_out;
  mem_in_type  dmem_in;
  mem_out_type dmem_out;
  mem_in_type  mem_in;
  mem_out_type mem_out;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;

  mem_arbiter_rr #(.timeout_cycles(8), .cnt_width(10)) dut (
    .clock    (clock),
    .reset    (reset),
    .imem_in  (imem_in),
    .imem_out (imem_out),
    .dmem_in  (dmem_in),
    .dmem_out (dmem_out),
    .mem_in   (mem_in),
    .mem_out  (mem_out)
  );

  always #5 clock = ~clock;

  initial begin
    #20000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic mem_in_type req(input logic instr, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [3:0] wstrb);
    mem_in_type r;
    r           = init_mem_in;
    r.mem_valid = 1'b1;
    r.mem_instr = instr;
    r.mem_addr  = addr;
    r.mem_wdata = wdata;
    r.mem_wstrb = wstrb;
    return r;
  endfunction

  function automatic mem_out_type rsp(input logic err, input logic [31:0] rdata);
    mem_out_type r;
    r.mem_ready = 1'b1;
    r.mem_error = err;
    r.mem_rdata = rdata;
    return r;
  endfunction

  // Advance to just after the next rising edge and return all inputs to idle.
  task automatic cyc();
    @(posedge clock);
    #2;
    imem_in = init_mem_in;
    dmem_in = init_mem_in;
    mem_out = init_mem_out;
  endtask

  initial begin
    reset   = 1'b0;
    imem_in = init_mem_in;
    dmem_in = init_mem_in;
    mem_out = init_mem_out;
    #3;
    chk("rst_mem_in",   128'(mem_in),   128'(init_mem_in));
    chk("rst_imem_out", 128'(imem_out), 128'(init_mem_out));
    chk("rst_dmem_out", 128'(dmem_out), 128'(init_mem_out));
    #4 reset = 1'b1;

    // Single fetch: valid at edge k, issue visible at k+2, response at k+4.
    cyc(); imem_in = req(1'b1, 32'h0000_0100, 32'h0, 4'h0); #1;
    chk("fetch_k_valid", 128'(mem_in.mem_valid), 128'(1'b0));
    cyc(); #1;
    chk("fetch_k1_valid", 128'(mem_in.mem_valid), 128'(1'b0));
    cyc(); #1;
    chk("fetch_k2_issue", 128'(mem_in), 128'(req(1'b1, 32'h0000_0100, 32'h0, 4'h0)));
    cyc(); #1;
    chk("fetch_k3_valid", 128'(mem_in.mem_valid), 128'(1'b0));
    chk("fetch_k3_ready", 128'(imem_out.mem_ready), 128'(1'b0));
    cyc(); mem_out = rsp(1'b0, 32'h0000_0013); #1;
    chk("fetch_imem_out", 128'(imem_out), 128'(rsp(1'b0, 32'h0000_0013)));
    chk("fetch_dmem_out", 128'(dmem_out), 128'(init_mem_out));
    cyc(); #1;
    chk("fetch_after", 128'(imem_out), 128'(init_mem_out));

    // Tie after an instruction grant: data goes first.
    cyc(); imem_in = req(1'b1, 32'h200, 32'h0, 4'h0); dmem_in = req(1'b0, 32'h300, 32'h0, 4'h0); #1;
    cyc(); #1;
    chk("tie_wait", 128'(mem_in.mem_valid), 128'(1'b0));
    cyc(); #1;
    chk("tie_first", 128'(mem_in), 128'(req(1'b0, 32'h300, 32'h0, 4'h0)));
    cyc(); mem_out = rsp(1'b0, 32'h0000_AAAA); #1;
    chk("tie_dmem_out", 128'(dmem_out), 128'(rsp(1'b0, 32'h0000_AAAA)));
    chk("tie_imem_quiet", 128'(imem_out), 128'(init_mem_out));
    cyc(); #1;
    chk("tie_gap", 128'(mem_in.mem_valid), 128'(1'b0));
    cyc(); #1;
    chk("tie_second", 128'(mem_in), 128'(req(1'b1, 32'h200, 32'h0, 4'h0)));
    cyc(); mem_out = rsp(1'b0, 32'h0000_BBBB); #1;
    chk("tie_imem_out", 128'(imem_out), 128'(rsp(1'b0, 32'h0000_BBBB)));
    chk("tie_dmem_quiet", 128'(dmem_out), 128'(init_mem_out));

    // Data store to an unmapped address: error passes straight through.
    cyc(); dmem_in = req(1'b0, 32'hF000_0000, 32'hDEAD_BEEF, 4'hF); #1;
    cyc(); #1;
    cyc(); #1;
    chk("err_issue", 128'(mem_in), 128'(req(1'b0, 32'hF000_0000, 32'hDEAD_BEEF, 4'hF)));
    cyc(); mem_out = rsp(1'b1, 32'h0); #1;
    chk("err_dmem_out", 128'(dmem_out), 128'(rsp(1'b1, 32'h0)));
    cyc(); #1;
    chk("err_one_cycle", 128'(dmem_out), 128'(init_mem_out));

    // Tie again after a data grant: instruction goes first.
    cyc(); imem_in = req(1'b1, 32'h400, 32'h0, 4'h0); dmem_in = req(1'b0, 32'h500, 32'h0, 4'h0); #1;
    cyc(); #1;
    cyc(); #1;
    chk("tie2_first", 128'(mem_in), 128'(req(1'b1, 32'h400, 32'h0, 4'h0)));
    cyc(); mem_out = rsp(1'b0, 32'h1); #1;
    chk("tie2_imem_out", 128'(imem_out), 128'(rsp(1'b0, 32'h1)));
    cyc(); #1;
    cyc(); #1;
    chk("tie2_second", 128'(mem_in), 128'(req(1'b0, 32'h500, 32'h0, 4'h0)));
    cyc(); mem_out = rsp(1'b0, 32'h2); #1;
    chk("tie2_dmem_out", 128'(dmem_out), 128'(rsp(1'b0, 32'h2)));

    // Watchdog: second imem valid while the entry is full is dropped; no response -> error after 8.
    cyc(); imem_in = req(1'b1, 32'h600, 32'h0, 4'h0); #1;
    cyc(); imem_in = req(1'b1, 32'h666, 32'h0, 4'h0); #1;
    cyc(); #1;
    chk("wd_issue", 128'(mem_in), 128'(req(1'b1, 32'h600, 32'h0, 4'h0)));
    for (int i = 1; i <= 7; i++) begin
      cyc(); #1;
      chk("wd_quiet", 128'(imem_out), 128'(init_mem_out));
    end
    cyc(); #1;
    chk("wd_expire", 128'(imem_out), 128'(rsp(1'b1, 32'h0)));
    chk("wd_dmem_quiet", 128'(dmem_out), 128'(init_mem_out));
    cyc(); #1;
    chk("wd_after", 128'(imem_out), 128'(init_mem_out));
    cyc(); #1;
    chk("wd_no_reissue", 128'(mem_in.mem_valid), 128'(1'b0));
    cyc(); mem_out = rsp(1'b0, 32'h99); #1;
    chk("late_ready_imem", 128'(imem_out), 128'(init_mem_out));
    chk("late_ready_dmem", 128'(dmem_out), 128'(init_mem_out));
    cyc(); #1;
    chk("late_no_issue", 128'(mem_in.mem_valid), 128'(1'b0));

    // Overlap: data request arriving during an instruction access waits for the idle cycle.
    cyc(); imem_in = req(1'b1, 32'h800, 32'h0, 4'h0); #1;
    cyc(); #1;
    cyc(); #1;
    chk("ov_issue_i", 128'(mem_in), 128'(req(1'b1, 32'h800, 32'h0, 4'h0)));
    cyc(); dmem_in = req(1'b0, 32'h700, 32'h1234_5678, 4'h3); #1;
    cyc(); #1;
    chk("ov_held", 128'(mem_in.mem_valid), 128'(1'b0));
    cyc(); mem_out = rsp(1'b0, 32'h55); #1;
    chk("ov_imem_out", 128'(imem_out), 128'(rsp(1'b0, 32'h55)));
    cyc(); #1;
    chk("ov_gap", 128'(mem_in.mem_valid), 128'(1'b0));
    cyc(); #1;
    chk("ov_issue_d", 128'(mem_in), 128'(req(1'b0, 32'h700, 32'h1234_5678, 4'h3)));
    cyc(); mem_out = rsp(1'b0, 32'h0); #1;
    chk("ov_dmem_out", 128'(dmem_out), 128'(rsp(1'b0, 32'h0)));

    // Reset while a data access is outstanding.
    cyc(); dmem_in = req(1'b0, 32'h900, 32'h0000_CAFE, 4'hF); #1;
    cyc(); #1;
    cyc(); #1;
    chk("rm_issue", 128'(mem_in), 128'(req(1'b0, 32'h900, 32'h0000_CAFE, 4'hF)));
    cyc(); #1;
    reset   = 1'b0;
    mem_out = rsp(1'b0, 32'h77);
    #1;
    chk("rm_mem_in",   128'(mem_in),   128'(init_mem_in));
    chk("rm_dmem_out", 128'(dmem_out), 128'(init_mem_out));
    chk("rm_imem_out", 128'(imem_out), 128'(init_mem_out));
    #1 reset = 1'b1;
    cyc(); mem_out = rsp(1'b0, 32'h77); #1;
    chk("rm_late_ready", 128'(dmem_out), 128'(init_mem_out));
    chk("rm_no_issue", 128'(mem_in.mem_valid), 128'(1'b0));
    cyc(); #1;
    chk("rm_idle", 128'(mem_in.mem_valid), 128'(1'b0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
